tmr_cmd_arbiter: RTL
====================

Name: tmr_cmd_arbiter

Overview:
- Consumer end of the bank-machine command stream. Accepts triplicated (TMR) command interfaces from NBANKS bank machines and majority-votes each copy.
- Arbitrates round-robin among banks whose command meets inter-command timing (tCCD, tRRD, tWTR), returns triplicated cmd_ready, and drives one registered single-phase DFI command slot.
- Sits between the bank machines and the PHY.

Parameters:
- NBANKS, 4, number of bank-machine ports.
- ABITS, 14, command address width.
- BABITS, 3, bank address width.
- TCCD, 2, minimum cycles between CAS commands (1 = back-to-back).
- TRRD, 2, minimum cycles between ACTIVATE commands.
- TWTR, 4, minimum cycles from WRITE issue to next READ issue.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- TMRcmd_valid  in  3*NBANKS  triplicated valid, bank b copy k at bit 3b+k.
- TMRcmd_ready  out  3*NBANKS  triplicated ready, all three copies identical.
- TMRcmd_payload_a  in  3*NBANKS*ABITS  address, slice (3b+k)*ABITS.
- TMRcmd_payload_ba  in  3*NBANKS*BABITS  bank address, same layout as a.
- TMRcmd_payload_cas / _ras / _we / _is_cmd / _is_read / _is_write  in  3*NBANKS each  command fields.
- dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n  out  1  DFI command, active-low.
- dfi_address  out  ABITS.
- dfi_bank  out  BABITS.
- dfi_wrdata_en, dfi_rddata_en  out  1.
- tmr_error  out  NBANKS  sticky per-bank TMR disagreement flag.

Behaviour:
- Voting: every field per bank is a bitwise majority (ab|bc|ac) of its 3 copies. All arbitration uses voted values only.
- Command classes (voted fields):
  - ACT = is_cmd & ras & ~cas & ~we.
  - RD = is_read.
  - WR = is_write.
  - Anything else (PRE, refresh, is_cmd-only) is always eligible.
- Eligibility:
  - ACT requires trrd_cnt==0.
  - RD requires ccd_cnt==0 and wtr_cnt==0.
  - WR requires ccd_cnt==0.
- Arbitration: each cycle, grant the first valid and eligible bank searching from rr_ptr+1 upward, modulo NBANKS.
  - At most one grant per cycle.
  - On grant, rr_ptr <= granted index.
  - Reset value of rr_ptr is NBANKS-1, so bank 0 has first priority.
  - Ineligible banks are skipped without blocking others.
- Handshake:
  - TMRcmd_ready for bank b is combinational: high in all 3 copies only in the cycle bank b is granted. Grant implies voted valid.
  - A bank holding valid with no grant keeps its command; nothing is dropped.
- Timing counters (3-bit saturating down-counters, decrement while nonzero):
  - Issuing CAS (RD or WR) loads ccd_cnt = TCCD-1.
  - Issuing ACT loads trrd_cnt = TRRD-1.
  - Issuing WR loads wtr_cnt = TWTR-1.
  - A load takes priority over a decrement in the same cycle.
- DFI output is registered, 1-cycle latency from grant.
  - Granted: cs_n=0, ras_n=~ras, cas_n=~cas, we_n=~we, address=a, bank=ba, wrdata_en=is_write, rddata_en=is_read.
  - Cycle without grant: NOP. cs_n=1, ras_n=cas_n=we_n=1, address=0, bank=0, enables=0.
- tmr_error[b] sets when the three copies of any field of bank b differ while voted valid is 1. Cleared only by reset.
- Reset (async, sys_rst_n=0):
  - All DFI outputs take NOP values (cs_n/ras_n/cas_n/we_n=1, address/bank=0, enables=0).
  - All counters are 0, rr_ptr=NBANKS-1, tmr_error=0.
  - TMRcmd_ready is forced 0 while reset is asserted.
  - Any command being granted in that cycle is lost; the bank re-presents it after release.
- Release is synchronous to sys_clk. The first grant can occur in the first cycle after sys_rst_n rises.

Test Plan:
- Bank 2 alone issues ACT (ras=1, a=0x1234, ba=2) on all 3 copies -> TMRcmd_ready[8:6]=3'b111 the same cycle; next cycle cs_n=0, ras_n=0, cas_n=1, we_n=1, dfi_address=0x1234, dfi_bank=2.
- Banks 0,1,3 hold WR continuously with TCCD=2 -> grants in order 0,1,3,0, spaced 2 cycles apart; dfi_wrdata_en high every other cycle; NOP in between.
- Bank 0 WR followed immediately by bank 1 RD with TWTR=4 -> RD granted exactly 4 cycles after WR; tmr_error stays 0.
- Bank 1 copy 2 has a=0x0FFF while copies 0/1 have 0x0001 -> dfi_address=0x0001 and tmr_error[1] goes to 1 and stays set after valid drops.
- Two ACTs from banks 0 and 3 in the same cycle with TRRD=2 -> bank 0 issued first, bank 3 two cycles later. A PRE on bank 1 offered in the intermediate cycle is granted there.
- Assert sys_rst_n=0 mid-stream -> DFI outputs immediately go to NOP, TMRcmd_ready=0; after release, bank 0 has priority and counters allow an immediate CAS.

Source files
------------

// File: rtl/tmr_cmd_arbiter.sv
// Round-robin command arbiter for triplicated bank-machine command ports.
// Majority-votes each port, enforces tCCD/tRRD/tWTR, issues one registered DFI command per cycle.
module tmr_cmd_arbiter #(
    parameter int NBANKS = 4,
    parameter int ABITS  = 14,
    parameter int BABITS = 3,
    parameter int TCCD   = 2,
    parameter int TRRD   = 2,
    parameter int TWTR   = 4
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [3*NBANKS-1:0]        TMRcmd_valid,
    output logic [3*NBANKS-1:0]        TMRcmd_ready,
    input  logic [3*NBANKS*ABITS-1:0]  TMRcmd_payload_a,
    input  logic [3*NBANKS*BABITS-1:0] TMRcmd_payload_ba,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_cas,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_ras,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_we,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_is_cmd,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_is_read,
    input  logic [3*NBANKS-1:0]        TMRcmd_payload_is_write,
    output logic                       dfi_cs_n,
    output logic                       dfi_ras_n,
    output logic                       dfi_cas_n,
    output logic                       dfi_we_n,
    output logic [ABITS-1:0]           dfi_address,
    output logic [BABITS-1:0]          dfi_bank,
    output logic                       dfi_wrdata_en,
    output logic                       dfi_rddata_en,
    output logic [NBANKS-1:0]          tmr_error
);

    localparam int PW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam logic [2:0] CCD_LD = 3'(TCCD - 1);
    localparam logic [2:0] RRD_LD = 3'(TRRD - 1);
    localparam logic [2:0] WTR_LD = 3'(TWTR - 1);

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    function automatic logic split3(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

    logic [ABITS-1:0]  w_a  [NBANKS];
    logic [BABITS-1:0] w_ba [NBANKS];
    logic [NBANKS-1:0] w_valid, w_cas, w_ras, w_we, w_is_cmd, w_is_read, w_is_write;
    logic [NBANKS-1:0] w_disagree, w_is_act, w_elig, w_req;

    logic [PW-1:0]     r_rr_ptr;
    logic [2:0]        r_ccd_cnt, r_trrd_cnt, r_wtr_cnt;
    logic              w_grant;
    logic [PW-1:0]     w_grant_idx;

    logic              r_cs_n, r_ras_n, r_cas_n, r_we_n, r_wrdata_en, r_rddata_en;
    logic [ABITS-1:0]  r_address;
    logic [BABITS-1:0] r_bank;
    logic [NBANKS-1:0] r_tmr_error;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [ABITS-1:0]  w_a0, w_a1, w_a2;
        logic [BABITS-1:0] w_b0, w_b1, w_b2;
        logic [2:0]        w_v3, w_cas3, w_ras3, w_we3, w_cmd3, w_rd3, w_wr3;

        assign w_a0   = TMRcmd_payload_a[(3*b+0)*ABITS +: ABITS];
        assign w_a1   = TMRcmd_payload_a[(3*b+1)*ABITS +: ABITS];
        assign w_a2   = TMRcmd_payload_a[(3*b+2)*ABITS +: ABITS];
        assign w_b0   = TMRcmd_payload_ba[(3*b+0)*BABITS +: BABITS];
        assign w_b1   = TMRcmd_payload_ba[(3*b+1)*BABITS +: BABITS];
        assign w_b2   = TMRcmd_payload_ba[(3*b+2)*BABITS +: BABITS];
        assign w_v3   = TMRcmd_valid[3*b +: 3];
        assign w_cas3 = TMRcmd_payload_cas[3*b +: 3];
        assign w_ras3 = TMRcmd_payload_ras[3*b +: 3];
        assign w_we3  = TMRcmd_payload_we[3*b +: 3];
        assign w_cmd3 = TMRcmd_payload_is_cmd[3*b +: 3];
        assign w_rd3  = TMRcmd_payload_is_read[3*b +: 3];
        assign w_wr3  = TMRcmd_payload_is_write[3*b +: 3];

        assign w_a[b]        = (w_a0 & w_a1) | (w_a1 & w_a2) | (w_a0 & w_a2);
        assign w_ba[b]       = (w_b0 & w_b1) | (w_b1 & w_b2) | (w_b0 & w_b2);
        assign w_valid[b]    = maj3(w_v3);
        assign w_cas[b]      = maj3(w_cas3);
        assign w_ras[b]      = maj3(w_ras3);
        assign w_we[b]       = maj3(w_we3);
        assign w_is_cmd[b]   = maj3(w_cmd3);
        assign w_is_read[b]  = maj3(w_rd3);
        assign w_is_write[b] = maj3(w_wr3);

        assign w_disagree[b] = (w_a0 != w_a1) || (w_a0 != w_a2) ||
                               (w_b0 != w_b1) || (w_b0 != w_b2) ||
                               split3(w_v3) || split3(w_cas3) || split3(w_ras3) ||
                               split3(w_we3) || split3(w_cmd3) || split3(w_rd3) ||
                               split3(w_wr3);

        // Each timing rule applies independently, so an odd mix of flags is held to all that match.
        assign w_is_act[b] = w_is_cmd[b] & w_ras[b] & ~w_cas[b] & ~w_we[b];
        assign w_elig[b]   = (!w_is_act[b] || (r_trrd_cnt == 3'd0)) &&
                             (!(w_is_read[b] || w_is_write[b]) || (r_ccd_cnt == 3'd0)) &&
                             (!w_is_read[b] || (r_wtr_cnt == 3'd0));
        assign w_req[b]    = w_valid[b] & w_elig[b];

        assign TMRcmd_ready[3*b +: 3] = {3{sys_rst_n & w_grant & (w_grant_idx == PW'(b))}};
    end

    // Rotating search starting just after the last granted bank.
    always_comb begin : p_arb
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        sum         = '0;
        idx         = '0;
        for (int i = 1; i <= NBANKS; i++) begin
            sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NBANKS)) begin
                sum = sum - (PW+1)'(NBANKS);
            end
            idx = sum[PW-1:0];
            if (!w_grant && w_req[idx]) begin
                w_grant     = 1'b1;
                w_grant_idx = idx;
            end
        end
    end

    logic w_sel_cas, w_sel_ras, w_sel_we, w_sel_rd, w_sel_wr, w_sel_act;
    assign w_sel_cas = w_cas[w_grant_idx];
    assign w_sel_ras = w_ras[w_grant_idx];
    assign w_sel_we  = w_we[w_grant_idx];
    assign w_sel_rd  = w_is_read[w_grant_idx];
    assign w_sel_wr  = w_is_write[w_grant_idx];
    assign w_sel_act = w_is_act[w_grant_idx];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rr_ptr    <= PW'(NBANKS - 1);
            r_ccd_cnt   <= 3'd0;
            r_trrd_cnt  <= 3'd0;
            r_wtr_cnt   <= 3'd0;
            r_cs_n      <= 1'b1;
            r_ras_n     <= 1'b1;
            r_cas_n     <= 1'b1;
            r_we_n      <= 1'b1;
            r_address   <= '0;
            r_bank      <= '0;
            r_wrdata_en <= 1'b0;
            r_rddata_en <= 1'b0;
            r_tmr_error <= '0;
        end else begin
            r_tmr_error <= r_tmr_error | (w_valid & w_disagree);

            if (w_grant && (w_sel_rd || w_sel_wr)) r_ccd_cnt <= CCD_LD;
            else if (r_ccd_cnt != 3'd0)            r_ccd_cnt <= r_ccd_cnt - 3'd1;

            if (w_grant && w_sel_act)              r_trrd_cnt <= RRD_LD;
            else if (r_trrd_cnt != 3'd0)           r_trrd_cnt <= r_trrd_cnt - 3'd1;

            if (w_grant && w_sel_wr)               r_wtr_cnt <= WTR_LD;
            else if (r_wtr_cnt != 3'd0)            r_wtr_cnt <= r_wtr_cnt - 3'd1;

            if (w_grant) begin
                r_rr_ptr    <= w_grant_idx;
                r_cs_n      <= 1'b0;
                r_ras_n     <= ~w_sel_ras;
                r_cas_n     <= ~w_sel_cas;
                r_we_n      <= ~w_sel_we;
                r_address   <= w_a[w_grant_idx];
                r_bank      <= w_ba[w_grant_idx];
                r_wrdata_en <= w_sel_wr;
                r_rddata_en <= w_sel_rd;
            end else begin
                r_cs_n      <= 1'b1;
                r_ras_n     <= 1'b1;
                r_cas_n     <= 1'b1;
                r_we_n      <= 1'b1;
                r_address   <= '0;
                r_bank      <= '0;
                r_wrdata_en <= 1'b0;
                r_rddata_en <= 1'b0;
            end
        end
    end

    assign dfi_cs_n      = r_cs_n;
    assign dfi_ras_n     = r_ras_n;
    assign dfi_cas_n     = r_cas_n;
    assign dfi_we_n      = r_we_n;
    assign dfi_address   = r_address;
    assign dfi_bank      = r_bank;
    assign dfi_wrdata_en = r_wrdata_en;
    assign dfi_rddata_en = r_rddata_en;
    assign tmr_error     = r_tmr_error;

endmodule
